// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word-addressed data memory with byte lanes, latency-1 reads and power-up clear
//
// Purpose: single-port data memory controller. One request per cycle is
// accepted while ready=1. Writes honour per-byte lane enables. Reads return
// the stored word one cycle after acceptance. Misaligned or out-of-range
// addresses are rejected with a one-cycle err pulse. With INIT_ZERO=1 the
// array is cleared one word per cycle after reset before requests are taken.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   req    in   1      access request, sampled when ready=1
//   we     in   1      1 = write, 0 = read
//   be     in   DW/8   byte-lane write enables
//   addr   in   AW     byte address
//   wdata  in   DW     write data
//   ready  out  1      request accepted this cycle if req=1
//   rvalid out  1      one-cycle pulse, rdata valid
//   rdata  out  DW     read data, held until next rvalid
//   err    out  1      one-cycle pulse, previous accepted request rejected
//   busy   out  1      initialisation in progress

module data_mem_ctrl #(
  parameter int DW        = 32,
  parameter int DEPTH     = 32,
  parameter int AW        = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            ready,
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            busy
);

  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t          r_state;
  logic [IW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_busy;
  logic            r_rvalid;
  logic            r_err;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_accept;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_bad;
  logic            w_wr;
  logic            w_rd;
  logic [IW-1:0]   w_idx;

  // Mask form keeps the lane-offset test valid even when DW=8 (no offset bits).
  assign w_accept       = req & r_ready;
  assign w_misaligned   = (addr & AW'(NB - 1)) != '0;
  assign w_out_of_range = (addr >> (BW + IW)) != '0;
  assign w_bad          = w_misaligned | w_out_of_range;
  assign w_idx          = addr[BW +: IW];
  assign w_wr           = w_accept & we & ~w_bad;
  assign w_rd           = w_accept & ~we & ~w_bad;

  // Array has no reset; INIT clears it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered outputs. A write at edge k is visible to a
  // read accepted at edge k+1 because the array is already updated then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RST_STATE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_busy   <= (INIT_ZERO != 0);
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= w_accept & w_bad;
      if (w_rd) begin
        r_rdata <= r_mem[w_idx];
      end
      case (r_state)
        S_INIT: begin
          // Counter parks at the last index; leaving INIT stops it.
          if (r_cnt == LAST_IDX) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rdata  = r_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl

module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DW=32, DEPTH=32, INIT_ZERO=1
  logic        rst_n, req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err, busy;
  logic [31:0] rdata;

  // Wide instance: DW=64, DEPTH=8, INIT_ZERO=0
  logic        rst2_n, req2, we2;
  logic [7:0]  be2;
  logic [31:0] addr2;
  logic [63:0] wdata2;
  logic        ready2, rvalid2, err2, busy2;
  logic [63:0] rdata2;

  data_mem_ctrl #(.DW(32), .DEPTH(32), .AW(32), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err),
    .busy(busy)
  );

  data_mem_ctrl #(.DW(64), .DEPTH(8), .AW(32), .INIT_ZERO(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .we(we2), .be(be2), .addr(addr2),
    .wdata(wdata2), .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .err(err2),
    .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain array of words plus the last returned read value.
  logic [31:0] m_mem [32];
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_rdata = 32'h0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic ev, output logic ee, output logic [31:0] ed);
    int idx;
    ev = 1'b0;
    ee = 1'b0;
    if (r) begin
      if ((a % 4) != 0 || a >= 32'd128) begin
        ee = 1'b1;
      end else begin
        idx = int'(a / 4);
        if (w) begin
          for (int l = 0; l < 4; l++)
            if (b[l]) m_mem[idx][8*l +: 8] = d[8*l +: 8];
        end else begin
          ev = 1'b1;
          m_rdata = m_mem[idx];
        end
      end
    end
    ed = m_rdata;
  endtask

  task automatic run_op(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic ev, ee;
    logic [31:0] ed;
    req = r; we = w; be = b; addr = a; wdata = d;
    model_step(r, w, b, a, d, ev, ee, ed);
    @(posedge clk); #1;
    req = 1'b0;
    chk({tag, "_rvalid"}, 64'(rvalid), 64'(ev));
    chk({tag, "_err"},    64'(err),    64'(ee));
    chk({tag, "_rdata"},  64'(rdata),  64'(ed));
  endtask

  // Counts edges from release until ready rises; req is dropped as soon as
  // ready is seen so the pending request is never accepted.
  task automatic wait_init(input string tag);
    int first;
    logic bad;
    first = -1;
    bad = 1'b0;
    for (int k = 1; k <= 100 && first < 0; k++) begin
      @(posedge clk); #1;
      if (ready) first = k;
      else if (!busy || rvalid || err) bad = 1'b1;
    end
    req = 1'b0;
    chk({tag, "_ready_edge"}, 64'(first), 64'd32);
    chk({tag, "_init_flags"}, 64'(bad), 64'd0);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic read_all_zero(input string tag);
    model_reset();
    for (int i = 0; i < 32; i++) run_op(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, tag);
  endtask

  typedef struct {
    logic        r, w;
    logic [3:0]  b;
    logic [31:0] a, d;
    logic        ev, ee;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [12];

  task automatic op2(input logic w, input logic [7:0] b, input logic [31:0] a,
                     input logic [63:0] d);
    req2 = 1'b1; we2 = w; be2 = b; addr2 = a; wdata2 = d;
    @(posedge clk); #1;
    req2 = 1'b0;
  endtask

  logic        rr, rw, ev, ee;
  logic [3:0]  rb;
  logic [31:0] ra, rd, ed;
  int          sel;

  initial begin
    tbl[0]  = '{1, 1, 4'hF, 32'h08, 32'hAABBCCDD, 0, 0, 32'h0};
    tbl[1]  = '{1, 1, 4'h5, 32'h08, 32'h11223344, 0, 0, 32'h0};
    tbl[2]  = '{1, 0, 4'h0, 32'h08, 32'h0,        1, 0, 32'hAA22CC44};
    tbl[3]  = '{1, 1, 4'hF, 32'h0C, 32'h12345678, 0, 0, 32'hAA22CC44};
    tbl[4]  = '{1, 0, 4'h0, 32'h0C, 32'h0,        1, 0, 32'h12345678};
    tbl[5]  = '{1, 0, 4'h0, 32'h0A, 32'h0,        0, 1, 32'h12345678};
    tbl[6]  = '{1, 0, 4'h0, 32'h80, 32'h0,        0, 1, 32'h12345678};
    tbl[7]  = '{1, 0, 4'h0, 32'h08, 32'h0,        1, 0, 32'hAA22CC44};
    tbl[8]  = '{1, 1, 4'h0, 32'h10, 32'hFFFFFFFF, 0, 0, 32'hAA22CC44};
    tbl[9]  = '{1, 0, 4'h0, 32'h10, 32'h0,        1, 0, 32'h00000000};
    tbl[10] = '{1, 1, 4'hF, 32'h0A, 32'hFFFFFFFF, 0, 1, 32'h00000000};
    tbl[11] = '{1, 0, 4'h0, 32'h08, 32'h0,        1, 0, 32'hAA22CC44};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    rst2_n = 1'b0; req2 = 1'b0; we2 = 1'b0; be2 = 8'h0; addr2 = 32'h0; wdata2 = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst2_ready", 64'(ready2), 64'd0);
    chk("rst2_busy", 64'(busy2), 64'd0);

    // A write to word 0 held during INIT must be ignored.
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init1");
    model_reset();

    run_op(1'b1, 1'b0, 4'h0, 32'h7C, 32'h0, "rd7c");
    read_all_zero("zero1");

    for (int i = 0; i < 12; i++) begin
      req = tbl[i].r; we = tbl[i].w; be = tbl[i].b; addr = tbl[i].a; wdata = tbl[i].d;
      model_step(tbl[i].r, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, ev, ee, ed);
      @(posedge clk); #1;
      req = 1'b0;
      chk($sformatf("vec%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].ee));
      chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].ed));
    end

    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 9) != 0);
      rw = 1'($urandom_range(0, 1));
      rb = 4'($urandom);
      rd = $urandom;
      sel = $urandom_range(0, 9);
      ra = 32'($urandom_range(0, 31) * 4);
      if (sel == 0) ra = $urandom;
      else if (sel == 1) ra = ra + 32'($urandom_range(1, 3));
      else if (sel == 2) ra = ra + 32'h80;
      run_op(rr, rw, rb, ra, rd, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset with a read presented but not yet accepted.
    run_op(1'b1, 1'b1, 4'hF, 32'h08, 32'hDEADBEEF, "pre_wr");
    run_op(1'b1, 1'b0, 4'h0, 32'h08, 32'h0, "pre_rd");
    req = 1'b1; we = 1'b0; addr = 32'h08;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdata", 64'(rdata), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd1);
    req = 1'b0;
    @(posedge clk); #1;
    chk("arst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort INIT at counter=10 and confirm a full restart.
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init3");
    read_all_zero("zero3");

    // Wide instance, no init clear.
    @(negedge clk);
    rst2_n = 1'b1;
    chk("w_ready_pre", 64'(ready2), 64'd0);
    @(posedge clk); #1;
    chk("w_ready_first", 64'(ready2), 64'd1);
    chk("w_busy", 64'(busy2), 64'd0);
    op2(1'b1, 8'hFF, 32'h38, 64'h0123456789ABCDEF);
    chk("w_wr_rvalid", 64'(rvalid2), 64'd0);
    chk("w_wr_err", 64'(err2), 64'd0);
    op2(1'b0, 8'h00, 32'h38, 64'h0);
    chk("w_rd_rvalid", 64'(rvalid2), 64'd1);
    chk("w_rd_rdata", rdata2, 64'h0123456789ABCDEF);
    op2(1'b0, 8'h00, 32'h40, 64'h0);
    chk("w_oor_err", 64'(err2), 64'd1);
    chk("w_oor_rvalid", 64'(rvalid2), 64'd0);
    chk("w_oor_rdata", rdata2, 64'h0123456789ABCDEF);
    op2(1'b0, 8'h00, 32'h3C, 64'h0);
    chk("w_mis_err", 64'(err2), 64'd1);
    op2(1'b1, 8'h0F, 32'h38, 64'hFFFFFFFFFFFFFFFF);
    op2(1'b0, 8'h00, 32'h38, 64'h0);
    chk("w_lane_rdata", rdata2, 64'h01234567FFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 32, number of words; SHALL be a power of 2, minimum 2.
REQ-003 Parameter AW, default 32, byte-address width; SHALL be at least log2(DEPTH)+log2(DW/8).
REQ-004 Parameter INIT_ZERO, default 1, meaning: 1 = clear all words after reset, 0 = no clear.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  1  access request, sampled when ready=1.
REQ-008 we  in  1  1 = write, 0 = read; qualified by req.
REQ-009 be  in  DW/8  byte-lane write enables; be[i] covers wdata[8i+7:8i].
REQ-010 addr  in  AW  byte address.
REQ-011 wdata  in  DW  write data.
REQ-012 ready  out  1  block accepts a request this cycle.
REQ-013 rvalid  out  1  one-cycle pulse: rdata valid.
REQ-014 rdata  out  DW  read data, registered, held until next rvalid.
REQ-015 err  out  1  one-cycle pulse: previous accepted request rejected.
REQ-016 busy  out  1  initialisation in progress.

Function
REQ-017 A request SHALL be accepted on a rising edge where req=1 and ready=1; all other req cycles SHALL be ignored with no side effect.
REQ-018 Word index SHALL be addr[log2(DW/8)+log2(DEPTH)-1 : log2(DW/8)].
REQ-019 An accepted request with nonzero addr[log2(DW/8)-1:0] (misaligned) or any nonzero addr bit above the word index (out of range) SHALL be rejected: no memory update, no rvalid, err=1 next cycle, rdata unchanged.
REQ-020 Accepted valid write SHALL update only lanes with be[i]=1 at that edge; be all-zero SHALL be a legal no-op; no rvalid for writes.
REQ-021 Accepted valid read SHALL drive rvalid=1 and rdata=stored word exactly one cycle later (latency 1).
REQ-022 Read accepted the cycle after a write to the same word SHALL return the post-write value.
REQ-023 ready SHALL be 1 in state RUN and 0 in state INIT; back-to-back accepts, one per cycle, SHALL be supported in RUN.
REQ-024 State machine: INIT (busy=1, counter steps 0..DEPTH-1 writing zero to one word per cycle) -> RUN after the write of word DEPTH-1; RUN holds until reset.
REQ-025 With INIT_ZERO=1, INIT SHALL last exactly DEPTH cycles after rst_n rises, and ready SHALL first be 1 in the cycle after the last clear write.
REQ-026 With INIT_ZERO=0, the block SHALL enter RUN directly; ready=1 from the first edge after rst_n rises; contents undefined until written.
REQ-027 The init counter SHALL be log2(DEPTH) bits, SHALL stop at DEPTH-1 and SHALL NOT wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=INIT (INIT_ZERO=1) or RUN (INIT_ZERO=0), counter=0, ready=0, rvalid=0, err=0, rdata=0, busy=INIT_ZERO.
REQ-029 Reset asserted mid-INIT or mid-transaction SHALL abort it; a read pending for rvalid SHALL NOT produce rvalid; with INIT_ZERO=1, init SHALL restart from word 0.
REQ-030 Memory array SHALL have no reset; with INIT_ZERO=1 it SHALL read all-zero once RUN is reached.

Verification
REQ-031 Defaults, release rst_n -> busy=1 and ready=0 for 32 cycles, then ready=1; read addr 0x7C -> rvalid next cycle with rdata=0x00000000.
REQ-032 Write addr 0x08 wdata 0xAABBCCDD be=4'b1111, then write 0x11223344 be=4'b0101, then read 0x08 -> rdata=0xAA22CC44.
REQ-033 Write 0x0C data 0x12345678, read 0x0C on the very next cycle -> rvalid with rdata=0x12345678.
REQ-034 Read addr 0x0A (misaligned) and addr 0x80 (out of range, DEPTH=32) -> err pulse each, no rvalid, rdata unchanged, memory unchanged.
REQ-035 Pull rst_n low at init counter=10, release -> busy restarts, full 32-cycle INIT, all words read 0.
REQ-036 DW=64, DEPTH=8, INIT_ZERO=0: ready=1 on first edge after reset; write addr 0x38 be=8'hFF, read back -> equal; read addr 0x40 -> err.
